// File: rtl/alu_rx_sequencer.sv
// -----------------------------------------------------------------------------
// alu_rx_sequencer
//
// Collects three bytes from a serial receiver (operand A, operand B, opcode),
// presents them as registered inputs to a combinational ALU, captures the ALU
// result and hands it to a byte transmitter through a start/done handshake.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_rx_data      received byte, qualified by i_rx_done
//   i_rx_done      one-cycle pulse, byte available
//   i_alu_result   combinational ALU output
//   i_tx_done      one-cycle pulse, transmitter finished
//   o_alu_data_A   registered operand A
//   o_alu_data_B   registered operand B
//   o_alu_op       registered opcode
//   o_tx_data      registered result byte for the transmitter
//   o_tx_start     one-cycle pulse, start transmitting o_tx_data
//   o_busy         high while a result is being computed/sent
//   o_error        one-cycle pulse after an invalid opcode byte
// -----------------------------------------------------------------------------
module alu_rx_sequencer #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_data_A,
    output logic [NB_DATA-1:0] o_alu_data_B,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_error
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        CALC,
        SEND,
        WAIT_TX
    } state_t;

    localparam int NUM_OPS = 8;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);

    // Table of legal opcodes, one NB_OP-wide slot per entry.
    localparam logic [NUM_OPS*NB_OP-1:0] OP_TABLE = {
        NB_OP'(6'b100000),  // ADD
        NB_OP'(6'b100010),  // SUB
        NB_OP'(6'b100100),  // AND
        NB_OP'(6'b100101),  // OR
        NB_OP'(6'b100110),  // XOR
        NB_OP'(6'b000011),  // SRA
        NB_OP'(6'b000010),  // SRL
        NB_OP'(6'b100111)   // NOR
    };

    state_t             state_reg,   state_next;
    logic [NB_DATA-1:0] data_a_reg,  data_a_next;
    logic [NB_DATA-1:0] data_b_reg,  data_b_next;
    logic [NB_OP-1:0]   op_reg,      op_next;
    logic [NB_DATA-1:0] tx_data_reg, tx_data_next;
    logic               tx_start_reg, tx_start_next;
    logic               busy_reg,    busy_next;
    logic               error_reg,   error_next;

    // ------------------------------------------------------------------
    // Opcode validation: upper bits must be zero and the low bits must
    // match one table entry.
    // ------------------------------------------------------------------
    logic [NUM_OPS-1:0] op_match;
    logic               upper_zero;
    logic               op_valid;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
            assign op_match[gi] =
                (i_rx_data[NB_OP-1:0] == OP_TABLE[gi*NB_OP +: NB_OP]);
        end
    endgenerate

    // Shift form keeps this legal even when NB_OP == NB_DATA.
    assign upper_zero = ((i_rx_data >> NB_OP) == '0);
    assign op_valid   = upper_zero && (|op_match);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= WAIT_A;
            data_a_reg   <= '0;
            data_b_reg   <= '0;
            op_reg       <= OP_ADD;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_a_reg   <= data_a_next;
            data_b_reg   <= data_b_next;
            op_reg       <= op_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            busy_reg     <= busy_next;
            error_reg    <= error_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        data_a_next  = data_a_reg;
        data_b_next  = data_b_reg;
        op_next      = op_reg;
        tx_data_next = tx_data_reg;
        error_next   = 1'b0;

        unique case (state_reg)
            WAIT_A: begin
                if (i_rx_done) begin
                    data_a_next = i_rx_data;
                    state_next  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    data_b_next = i_rx_data;
                    state_next  = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    if (op_valid) begin
                        op_next    = i_rx_data[NB_OP-1:0];
                        state_next = CALC;
                    end else begin
                        // Bad opcode aborts the command; the op register
                        // keeps the last legal opcode.
                        error_next = 1'b1;
                        state_next = WAIT_A;
                    end
                end
            end
            CALC: begin
                // ALU inputs have been stable for a full cycle here.
                tx_data_next = i_alu_result;
                state_next   = SEND;
            end
            SEND: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase

        // Registered outputs are decoded from the state being entered so
        // they line up with that state without any combinational path.
        tx_start_next = (state_next == SEND);
        busy_next     = (state_next == CALC) || (state_next == SEND) ||
                        (state_next == WAIT_TX);
    end

    assign o_alu_data_A = data_a_reg;
    assign o_alu_data_B = data_b_reg;
    assign o_alu_op     = op_reg;
    assign o_tx_data    = tx_data_reg;
    assign o_tx_start   = tx_start_reg;
    assign o_busy       = busy_reg;
    assign o_error      = error_reg;

endmodule

// File: tb/tb_alu_rx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_rx_sequencer
//
// Self-checking bench for alu_rx_sequencer. A behavioural ALU is attached to
// the operand outputs; expected transmit bytes are queued when a command is
// issued and compared when o_tx_start fires.
// -----------------------------------------------------------------------------
module tb_alu_rx_sequencer;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic [NB_DATA-1:0] rx_data;
    logic               rx_done;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done;
    logic [NB_DATA-1:0] alu_data_a;
    logic [NB_DATA-1:0] alu_data_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               busy;
    logic               error;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    logic [NB_DATA-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_rx_sequencer #(
        .NB_DATA(NB_DATA),
        .NB_OP  (NB_OP)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_data_A (alu_data_a),
        .o_alu_data_B (alu_data_b),
        .o_alu_op     (alu_op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy),
        .o_error      (error)
    );

    // Behavioural ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            6'b100000: alu_result = alu_data_a + alu_data_b;
            6'b100010: alu_result = alu_data_a - alu_data_b;
            6'b100100: alu_result = alu_data_a & alu_data_b;
            6'b100101: alu_result = alu_data_a | alu_data_b;
            6'b100110: alu_result = alu_data_a ^ alu_data_b;
            6'b000011: alu_result = $signed(alu_data_a) >>> alu_data_b;
            6'b000010: alu_result = alu_data_a >> alu_data_b;
            6'b100111: alu_result = ~(alu_data_a | alu_data_b);
            default:   alu_result = '0;
        endcase
    end

    // Scoreboard: every transmit start consumes one queued expectation.
    always @(negedge clk) begin
        if (!reset && tx_start) begin
            logic [NB_DATA-1:0] exp_byte;
            starts++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_start_unexpected: tx_data=%02h, no result expected", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (tx_data !== exp_byte) begin
                    errors++;
                    $display("FAIL tx_data: got %02h expected %02h", tx_data, exp_byte);
                end else begin
                    $display("tx byte %02h ok", tx_data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [NB_DATA-1:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = NB_DATA'($urandom);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic finish_tx();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Full valid command with cycle-accurate checks around the opcode.
    task automatic run_valid(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] res);
        int s0;
        s0 = starts;
        exp_q.push_back(res);
        send_byte(a);
        checks++;
        if (alu_data_a !== a) begin
            errors++;
            $display("FAIL load_a: got %02h expected %02h", alu_data_a, a);
        end
        send_byte(b);
        checks++;
        if (alu_data_b !== b) begin
            errors++;
            $display("FAIL load_b: got %02h expected %02h", alu_data_b, b);
        end
        send_byte(op);
        // One cycle after the opcode edge: busy, op loaded, no start yet.
        checks++;
        if (busy !== 1'b1 || alu_op !== op[NB_OP-1:0] || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL calc_cycle: busy=%b op=%02h start=%b expected busy=1 op=%02h start=0",
                     busy, alu_op, tx_start, op[NB_OP-1:0]);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: start=%b busy=%b expected 1/1", tx_start, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_width: start=%b busy=%b expected 0/1", tx_start, busy);
        end
        tick(3);
        finish_tx();
        checks++;
        if (busy !== 1'b0 || (starts - s0) != 1) begin
            errors++;
            $display("FAIL tx_done: busy=%b starts=%0d expected busy=0 starts=1",
                     busy, starts - s0);
        end
        $display("cmd a=%02h b=%02h op=%02h expect=%02h done", a, b, op, res);
    endtask

    task automatic run_invalid(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] op, input logic [NB_OP-1:0] prev_op);
        int s0;
        s0 = starts;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || alu_op !== prev_op) begin
            errors++;
            $display("FAIL invalid_op %02h: error=%b busy=%b op=%02h expected 1/0/%02h",
                     op, error, busy, alu_op, prev_op);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL error_width: error=%b start=%b expected 0/0", error, tx_start);
        end
        tick(4);
        checks++;
        if ((starts - s0) != 0 || alu_op !== prev_op) begin
            errors++;
            $display("FAIL invalid_no_tx: starts=%0d op=%02h expected 0/%02h",
                     starts - s0, alu_op, prev_op);
        end
        $display("invalid cmd op=%02h done", op);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset   = 1'b1;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_data_a !== 8'h00 || alu_data_b !== 8'h00 || alu_op !== 6'b100000 ||
            tx_data !== 8'h00 || tx_start !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: A=%02h B=%02h op=%02h tx=%02h st=%b busy=%b err=%b expected 00/00/20/00/0/0/0",
                     alu_data_a, alu_data_b, alu_op, tx_data, tx_start, busy, error);
        end
        $display("reset check done");
    endtask

    task automatic test_add();
        run_valid(8'h05, 8'h03, 8'h20, 8'h08);
    endtask

    task automatic test_sub_nor();
        run_valid(8'h03, 8'h05, 8'h22, 8'hFE);
        run_valid(8'hF0, 8'h0F, 8'h27, 8'h00);
    endtask

    task automatic test_invalid();
        run_invalid(8'h11, 8'h22, 8'h3F, 6'b100111);
        // Command following an error must start again at operand A.
        run_valid(8'h0C, 8'h06, 8'h24, 8'h04);
    endtask

    task automatic test_upper_bits();
        run_invalid(8'h11, 8'h22, 8'hE0, 6'b100100);
    endtask

    task automatic test_back_pressure();
        int s0;
        int busy_low;
        s0 = starts;
        busy_low = 0;
        exp_q.push_back(8'h09);
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge clk);   // start cycle, checked by the scoreboard
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_low++;
            rx_done = (i == 10 || i == 40 || i == 70);
            rx_data = (i == 10) ? 8'hAA : (i == 40) ? 8'hBB : 8'h21;
        end
        @(negedge clk);
        rx_done = 1'b0;
        checks++;
        if (busy_low != 0 || (starts - s0) != 1) begin
            errors++;
            $display("FAIL backpressure_busy: busy_low_cycles=%0d starts=%0d expected 0/1",
                     busy_low, starts - s0);
        end
        checks++;
        if (alu_data_a !== 8'h07 || alu_data_b !== 8'h02 || alu_op !== 6'b100000) begin
            errors++;
            $display("FAIL backpressure_regs: A=%02h B=%02h op=%02h expected 07/02/20",
                     alu_data_a, alu_data_b, alu_op);
        end
        finish_tx();
        run_valid(8'h55, 8'h01, 8'h20, 8'h56);
        $display("back-pressure scenario done");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h09);
        send_byte(8'h04);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (alu_data_a !== 8'h00 || alu_data_b !== 8'h00 || alu_op !== 6'b100000 ||
            tx_data !== 8'h00 || tx_start !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: A=%02h B=%02h op=%02h tx=%02h st=%b busy=%b err=%b expected 00/00/20/00/0/0/0",
                     alu_data_a, alu_data_b, alu_op, tx_data, tx_start, busy, error);
        end
        // Stray tx_done after reset must be ignored.
        finish_tx();
        run_valid(8'h02, 8'h01, 8'h20, 8'h03);
        $display("mid-command reset scenario done");
    endtask

    task automatic test_reset_in_wait_tx();
        exp_q.push_back(8'h0F);
        send_byte(8'h0A);
        send_byte(8'h05);
        send_byte(8'h25);
        tick(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_wait_tx: busy=%b tx=%02h expected 0/00", busy, tx_data);
        end
        run_valid(8'h06, 8'h01, 8'h02, 8'h03);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_nor();
        test_invalid();
        test_upper_bits();
        test_back_pressure();
        test_reset_mid();
        test_reset_in_wait_tx();
        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never transmitted, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_rx_sequencer.md
# alu_rx_sequencer

Command sequencer between a byte receiver/transmitter pair and the combinational ALU. Collects three received bytes (operand A, operand B, opcode), drives them onto the ALU inputs, and captures the ALU result. Sends the result back through a start/done transmit handshake. It replaces button-driven operand loading, so the ALU can be exercised from a serial link.

## Interface
- NB_DATA, 8, operand/result width and byte width of rx/tx data
- NB_OP, 6, ALU opcode width (NB_OP <= NB_DATA)
- i_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  received byte, valid only when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, byte available
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
- o_alu_data_A  out  NB_DATA  registered operand A to ALU
- o_alu_data_B  out  NB_DATA  registered operand B to ALU
- o_alu_op  out  NB_OP  registered opcode to ALU
- o_tx_data  out  NB_DATA  registered result byte for transmitter
- o_tx_start  out  1  one-cycle pulse, begin transmitting o_tx_data
- o_busy  out  1  high while a result is being computed/sent
- o_error  out  1  one-cycle pulse on invalid opcode byte

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX. The reset state is WAIT_A.
- WAIT_A + i_rx_done: o_alu_data_A <= i_rx_data; next state WAIT_B.
- WAIT_B + i_rx_done: o_alu_data_B <= i_rx_data; next state WAIT_OP.
- WAIT_OP + i_rx_done: the byte is valid iff bits [NB_DATA-1:NB_OP] are zero and bits [NB_OP-1:0] are one of ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Valid byte: o_alu_op <= byte[NB_OP-1:0]; next state CALC.
  - Invalid byte: o_alu_op unchanged; o_error=1 the next cycle; next state WAIT_A; no transmission.
- CALC: o_tx_data <= i_alu_result; next state SEND. The ALU inputs have been stable for one full cycle at this point.
- SEND: o_tx_start=1 for exactly this cycle; next state WAIT_TX.
- WAIT_TX: hold until i_tx_done=1, then next state WAIT_A. o_tx_data stays stable until the next CALC.
- o_busy=1 in CALC, SEND and WAIT_TX; otherwise 0.
- i_rx_done in CALC, SEND or WAIT_TX is dropped: no register changes, no state change.
- i_tx_done outside WAIT_TX is ignored.
- Operands are not cleared between commands. The A, B and op registers hold their last loaded values.
- Arithmetic is performed entirely in the ALU; this block never modifies the result. Width is NB_DATA, wrap-around is the ALU's.

## Timing
- Reset values: o_alu_data_A=0, o_alu_data_B=0, o_alu_op=100000 (ADD), o_tx_data=0, o_tx_start=0, o_busy=0, o_error=0, state WAIT_A.
- Reset takes effect on the clock edge where i_reset=1 and overrides everything, including mid-command (after A or B) and mid-WAIT_TX.
  - After reset, the next received byte is treated as operand A.
  - An i_tx_done arriving after reset is ignored.
- Let the opcode i_rx_done be sampled at edge t. Then:
  - State is CALC after edge t; the new o_alu_op is visible in cycle t+1.
  - o_tx_data is updated at edge t+1.
  - o_tx_start is high during cycle t+2 (after edge t+1, until edge t+2).
  - o_busy rises after edge t.
  - Latency from opcode byte to o_tx_start is 2 cycles.
- o_error is high during the single cycle after the invalid opcode's i_rx_done edge.
- i_tx_done sampled at edge u returns the state to WAIT_A after edge u. The earliest i_rx_done that is accepted as A is sampled at edge u+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then bytes 0x05, 0x03, 0x20 (ADD) with the ALU model attached:
  - o_alu_data_A=0x05, o_alu_data_B=0x03, o_alu_op=100000.
  - o_tx_start pulses exactly once, 2 cycles after the opcode byte, with o_tx_data=0x08.
  - o_busy stays high until i_tx_done.
- Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; then 0xF0, 0x0F, 0x27 (NOR) -> o_tx_data=0x00.
- Bytes 0x11, 0x22, 0x3F (invalid):
  - o_error pulses for one cycle and o_tx_start never asserts.
  - o_alu_op keeps its previous value.
  - The next byte loads A.
- Byte 0xE0 as opcode (nonzero upper bits, low bits match ADD) -> treated as invalid, o_error pulse.
- Back-pressure: hold i_tx_done low for 100 cycles after o_tx_start while sending 3 extra rx bytes.
  - o_tx_start stays single and o_busy stays 1.
  - A, B and op are unchanged; the extra bytes are dropped.
  - After i_tx_done, the next byte loads A.
- Reset mid-sequence: send A=0x09 and B=0x04, then pulse i_reset.
  - All outputs return to their reset values.
  - The subsequent 0x02, 0x01, 0x20 produce o_tx_data=0x03.
